load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the RV32 data-memory interface. Sits between the core's execute stage and the word-addressed data memory.
- Accepts byte, halfword and word load/store requests via a valid/ready handshake.
- Drives the memory's word-wide port. Sub-word stores are done as read-modify-write. Load data is aligned and sign/zero-extended.
- Flags misaligned, out-of-range and illegal-funct3 requests without touching memory.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in the attached memory. Byte addresses >= 4*MEM_WORDS are out of range.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3 (load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW)
- req_addr  in  32  byte address
- req_wdata  in  32  store data; bits [7:0] used for SB, bits [15:0] for SH
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  extended load result; 0 for stores and errors
- resp_error  out  1  request rejected; qualified by resp_valid
- mem_write  out  1  memory write enable
- mem_address  out  32  word-aligned byte address {addr_q[31:2], 2'b00}
- mem_write_data  out  32  merged word to write
- mem_read_data  in  32  combinational read data from memory at mem_address

Behaviour:
- Reset:
  - state = IDLE.
  - resp_valid=0, resp_rdata=0, resp_error=0.
  - addr_q, wdata_q, funct3_q, we_q, rdbuf = 0.
- mem_write is combinationally gated by !reset, so no memory write occurs in any cycle where reset is high, including reset arriving mid-WRITE.
- Handshake:
  - A request is accepted on a rising edge where req_valid && req_ready.
  - All request fields are latched at acceptance. req_* is ignored while req_ready=0.
- Error check at acceptance. The request is an error if any of the following hold:
  - funct3 is illegal for the direction: load 011/110/111; store anything other than 000/001/010.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - addr >= 4*MEM_WORDS.
- States:
  - IDLE: req_ready=1. On accept: error -> RESP with error flag set; otherwise -> READ.
  - READ: mem_address driven from addr_q, mem_write=0, rdbuf <= mem_read_data. Load -> RESP. Store -> WRITE.
  - WRITE: mem_write=1 for exactly this cycle. mem_write_data = rdbuf with the target lanes replaced:
    - SB: lane addr_q[1:0] <= wdata_q[7:0].
    - SH: lanes {addr_q[1],0}..{addr_q[1],1} <= wdata_q[15:0].
    - SW: full word.
    - Next state: RESP.
  - RESP: resp_valid=1 for exactly one cycle, then -> IDLE.
- Load extraction (registered into resp_rdata on entry to RESP):
  - Select the byte/halfword from rdbuf by addr_q[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- resp_rdata and resp_error hold their last values outside resp_valid.
- Latency, with request accepted at edge N:
  - Load: resp_valid high in cycle N+2.
  - Store: resp_valid high in cycle N+3.
  - Error: resp_valid high in cycle N+1.
- Throughput: one request outstanding; the next accept is at the earliest on the edge ending RESP+IDLE cycle.
- In IDLE and RESP, mem_write=0. mem_address is always driven from addr_q.

Test Plan:
- Loads from a byte: preload mem[1]=0x8899AABB.
  - LB 0x5 -> resp_rdata=0xFFFFFFAA.
  - LBU 0x5 -> 0x000000AA.
  - resp_valid at N+2, resp_error=0, mem_write never asserted.
- Halfword and word loads, same preload:
  - LH 0x6 -> 0xFFFF8899.
  - LHU 0x6 -> 0x00008899.
  - LW 0x4 -> 0x8899AABB.
- Sub-word and word stores:
  - SB 0x7 data 0x12345655 -> mem[1]=0x5599AABB.
  - Then SH 0x4 data 0x0000CAFE -> mem[1]=0x5599CAFE.
  - Then SW 0x4 data 0xDEADBEEF -> mem[1]=0xDEADBEEF.
  - Each store asserts mem_write exactly 1 cycle; resp_valid at N+3, resp_rdata=0.
- Each of the following -> resp_valid and resp_error=1 at N+1, mem_write never high, memory unchanged:
  - LW 0x6 (misaligned).
  - SH 0x3 (misaligned).
  - Load with funct3=011 (illegal).
  - LW 0x400 with MEM_WORDS=256 (out of range).
- Handshake under back-to-back traffic:
  - req_valid held high with three back-to-back LW requests.
  - req_ready low except in IDLE.
  - Exactly three accepts and three resp_valid pulses, in order.
- Reset mid-store:
  - Assert reset during the WRITE cycle of SB 0x4 data 0x77.
  - Memory is unchanged, mem_write=0 that cycle.
  - Next cycle: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bundle of request/response handshake and word-wide memory port signals.
// The master side is the core/memory environment; the slave side is the unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_write, mem_address, mem_write_data
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_write, mem_address, mem_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32 load/store initiator: one outstanding request, read-modify-write for
// sub-word stores, aligned and extended load data, rejection of bad requests.
module load_store_unit #(
    parameter int MEM_WORDS = 256
) (
    input logic             clk,
    input logic             reset,
    load_store_unit_if.slave bus
);
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_reg, state_next;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [2:0]  funct3_reg;
    logic        we_reg;
    logic [31:0] rdbuf_reg;
    logic [31:0] resp_rdata_reg;
    logic        resp_error_reg;

    logic        accept;
    logic        req_error;
    logic        funct3_legal;
    logic        misaligned;
    logic        out_of_range;
    logic [31:0] load_result;
    logic [31:0] shifted_word;
    logic [15:0] sel_half;
    logic [3:0][7:0] merged_lanes;

    assign accept = bus.req_valid && (state_reg == IDLE);

    always_comb begin
        funct3_legal = 1'b0;
        if (bus.req_we) begin
            funct3_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                           (bus.req_funct3 == 3'b010);
        end else begin
            funct3_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                           (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                           (bus.req_funct3 == 3'b101);
        end
        misaligned   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        out_of_range = ({1'b0, bus.req_addr} >= ADDR_LIMIT);
        req_error    = !funct3_legal || misaligned || out_of_range;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = req_error ? RESP : READ;
            READ:    state_next = we_reg ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Load result is extracted straight from the memory word in READ, which is
    // the same value rdbuf captures on that edge.
    always_comb begin
        shifted_word = bus.mem_read_data >> {addr_reg[1:0], 3'b000};
        sel_half     = addr_reg[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
        case (funct3_reg)
            3'b000:  load_result = {{24{shifted_word[7]}}, shifted_word[7:0]};
            3'b001:  load_result = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_result = {24'd0, shifted_word[7:0]};
            3'b101:  load_result = {16'd0, sel_half};
            default: load_result = bus.mem_read_data;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic lane_hit;
            logic [7:0] lane_src;
            assign lane_hit = (funct3_reg[1:0] == 2'b10) ||
                              ((funct3_reg[1:0] == 2'b01) && (addr_reg[1] == LANE[1])) ||
                              ((funct3_reg[1:0] == 2'b00) && (addr_reg[1:0] == LANE));
            assign lane_src = (funct3_reg[1:0] == 2'b10) ? wdata_reg[8*gi +: 8] :
                              (funct3_reg[1:0] == 2'b01) ? wdata_reg[8*(gi%2) +: 8] :
                                                           wdata_reg[7:0];
            assign merged_lanes[gi] = lane_hit ? lane_src : rdbuf_reg[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            funct3_reg     <= '0;
            we_reg         <= 1'b0;
            rdbuf_reg      <= '0;
            resp_rdata_reg <= '0;
            resp_error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        addr_reg   <= bus.req_addr;
                        wdata_reg  <= bus.req_wdata;
                        funct3_reg <= bus.req_funct3;
                        we_reg     <= bus.req_we;
                        if (req_error) begin
                            resp_rdata_reg <= '0;
                            resp_error_reg <= 1'b1;
                        end
                    end
                end
                READ: begin
                    rdbuf_reg <= bus.mem_read_data;
                    if (!we_reg) begin
                        resp_rdata_reg <= load_result;
                        resp_error_reg <= 1'b0;
                    end
                end
                WRITE: begin
                    resp_rdata_reg <= '0;
                    resp_error_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready      = (state_reg == IDLE);
    assign bus.resp_valid     = (state_reg == RESP);
    assign bus.resp_rdata     = resp_rdata_reg;
    assign bus.resp_error     = resp_error_reg;
    // Gated by reset so a reset landing in WRITE never commits the merged word.
    assign bus.mem_write      = (state_reg == WRITE) && !reset;
    assign bus.mem_address    = {addr_reg[31:2], 2'b00};
    assign bus.mem_write_data = merged_lanes;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small word memory
// model attached to the memory port.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if bus();
    load_store_unit #(.MEM_WORDS(256)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [31:0] mem [0:255];
    logic        preload_en = 1'b0;
    logic [7:0]  preload_idx = '0;
    logic [31:0] preload_data = '0;
    int          wr_count = 0;
    int          vectors = 0;
    int          errors = 0;

    always @(posedge clk) begin
        if (preload_en) mem[preload_idx] <= preload_data;
        else if (bus.mem_write) mem[bus.mem_address[9:2]] <= bus.mem_write_data;
    end
    assign bus.mem_read_data = mem[bus.mem_address[9:2]];

    always @(negedge clk) if (bus.mem_write) wr_count++;

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        @(negedge clk);
        preload_en = 1'b1; preload_idx = idx; preload_data = data;
        @(posedge clk); #1;
        preload_en = 1'b0;
    endtask

    // Issues one request from IDLE and measures response latency in cycles
    // after the accepting edge; lat=0 means no response within the budget.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat, output int writes);
        int  wr0;
        bit  done;
        @(negedge clk);
        wr0 = wr_count;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0; done = 1'b0; rdata = '0; err = 1'b0;
        for (int k = 1; k <= 8 && !done; k++) begin
            if (bus.resp_valid) begin
                lat = k; rdata = bus.resp_rdata; err = bus.resp_error; done = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        writes = wr_count - wr0;
        @(posedge clk);
        $display("req we=%b f3=%b addr=%h wdata=%h -> rdata=%h err=%b lat=%0d writes=%0d",
                 we, f3, addr, wdata, rdata, err, lat, writes);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.mem_write !== 1'b0) begin
            errors++; $display("FAIL reset_mem_write got %b want 0", bus.mem_write);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready);
        end
        vectors++;
        if (bus.resp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid);
        end
        vectors++;
        if (bus.resp_rdata !== 32'h0 || bus.resp_error !== 1'b0) begin
            errors++; $display("FAIL reset_resp got rdata=%h err=%b want 0/0",
                               bus.resp_rdata, bus.resp_error);
        end
        vectors++;
        if (bus.mem_address !== 32'h0) begin
            errors++; $display("FAIL reset_mem_address got %h want 0", bus.mem_address);
        end
        $display("reset done");
    endtask

    task automatic test_loads;
        logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] addrs[5] = '{32'h5, 32'h5, 32'h6, 32'h6, 32'h4};
        logic [31:0] exps [5] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899,
                                  32'h00008899, 32'h8899AABB};
        logic [31:0] rd;
        logic        er;
        int          lat, wr;
        preload(8'd1, 32'h8899AABB);
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, f3s[i], addrs[i], 32'h0, rd, er, lat, wr);
            vectors++;
            if (rd !== exps[i]) begin
                errors++; $display("FAIL load%0d_rdata got %h want %h", i, rd, exps[i]);
            end
            vectors++;
            if (lat !== 2 || er !== 1'b0 || wr !== 0) begin
                errors++; $display("FAIL load%0d_timing got lat=%0d err=%b writes=%0d want 2/0/0",
                                   i, lat, er, wr);
            end
        end
    endtask

    task automatic test_stores;
        logic [2:0]  f3s  [3] = '{3'b000, 3'b001, 3'b010};
        logic [31:0] addrs[3] = '{32'h7, 32'h4, 32'h4};
        logic [31:0] wds  [3] = '{32'h12345655, 32'h0000CAFE, 32'hDEADBEEF};
        logic [31:0] exps [3] = '{32'h5599AABB, 32'h5599CAFE, 32'hDEADBEEF};
        logic [31:0] rd;
        logic        er;
        int          lat, wr;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b1, f3s[i], addrs[i], wds[i], rd, er, lat, wr);
            vectors++;
            if (mem[1] !== exps[i]) begin
                errors++; $display("FAIL store%0d_mem got %h want %h", i, mem[1], exps[i]);
            end
            vectors++;
            if (lat !== 3 || er !== 1'b0 || wr !== 1 || rd !== 32'h0) begin
                errors++; $display("FAIL store%0d_resp got lat=%0d err=%b writes=%0d rdata=%h want 3/0/1/0",
                                   i, lat, er, wr, rd);
            end
        end
    endtask

    task automatic test_errors;
        logic        wes  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3s  [4] = '{3'b010, 3'b001, 3'b011, 3'b010};
        logic [31:0] addrs[4] = '{32'h6, 32'h3, 32'h0, 32'h400};
        logic [31:0] rd;
        logic        er;
        int          lat, wr;
        preload(8'd0, 32'h11223344);
        for (int i = 0; i < 4; i++) begin
            do_req(wes[i], f3s[i], addrs[i], 32'hFFFFFFFF, rd, er, lat, wr);
            vectors++;
            if (er !== 1'b1 || lat !== 1 || rd !== 32'h0) begin
                errors++; $display("FAIL error%0d_resp got err=%b lat=%0d rdata=%h want 1/1/0",
                                   i, er, lat, rd);
            end
            vectors++;
            if (wr !== 0 || mem[0] !== 32'h11223344 || mem[1] !== 32'hDEADBEEF) begin
                errors++; $display("FAIL error%0d_mem got writes=%0d mem0=%h mem1=%h want 0/11223344/deadbeef",
                                   i, wr, mem[0], mem[1]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exps[3] = '{32'h11223344, 32'hDEADBEEF, 32'h0BADF00D};
        int n_acc = 0;
        int n_resp = 0;
        preload(8'd2, 32'h0BADF00D);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c < 9) begin
                vectors++;
                if (bus.req_ready !== (c % 3 == 0)) begin
                    errors++; $display("FAIL b2b_ready_c%0d got %b want %b", c, bus.req_ready, (c % 3 == 0));
                end
                vectors++;
                if (bus.resp_valid !== (c % 3 == 2)) begin
                    errors++; $display("FAIL b2b_resp_valid_c%0d got %b want %b", c, bus.resp_valid, (c % 3 == 2));
                end
            end
            if (bus.resp_valid) begin
                if (n_resp < 3) begin
                    vectors++;
                    if (bus.resp_rdata !== exps[n_resp] || bus.resp_error !== 1'b0) begin
                        errors++; $display("FAIL b2b_rdata%0d got %h err=%b want %h", n_resp,
                                           bus.resp_rdata, bus.resp_error, exps[n_resp]);
                    end
                end
                $display("b2b resp %0d rdata=%h", n_resp, bus.resp_rdata);
                n_resp++;
            end
            if (n_acc < 3) begin
                bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
                bus.req_addr = 32'(4 * n_acc); bus.req_wdata = 32'h0;
            end else begin
                bus.req_valid = 1'b0;
            end
            if (bus.req_valid && bus.req_ready) n_acc++;
        end
        bus.req_valid = 1'b0;
        vectors++;
        if (n_acc !== 3 || n_resp !== 3) begin
            errors++; $display("FAIL b2b_counts got accepts=%0d resps=%0d want 3/3", n_acc, n_resp);
        end
    endtask

    task automatic test_reset_mid_store;
        int wr0;
        preload(8'd1, 32'hA5A5A5A5);
        @(negedge clk);
        wr0 = wr_count;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h4; bus.req_wdata = 32'h77;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (bus.mem_write !== 1'b1) begin
            errors++; $display("FAIL rst_store_in_write got mem_write=%b want 1", bus.mem_write);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.mem_write !== 1'b0) begin
            errors++; $display("FAIL rst_store_gate got mem_write=%b want 0", bus.mem_write);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_store_state got ready=%b valid=%b rdata=%h want 1/0/0",
                               bus.req_ready, bus.resp_valid, bus.resp_rdata);
        end
        vectors++;
        if (mem[1] !== 32'hA5A5A5A5 || wr_count != wr0) begin
            errors++; $display("FAIL rst_store_mem got mem1=%h writes=%0d want a5a5a5a5/0",
                               mem[1], wr_count - wr0);
        end
        @(negedge clk);
        reset = 1'b0;
        $display("reset mid-store: mem1=%h", mem[1]);
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_back_to_back();
        test_reset_mid_store();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
